// File: rtl/bip_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// bip_defs : shared opcode, select, ALU and FSM encodings for the BIP I core
// Revision : 1.0
// ============================================================================
package bip_defs;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_HLT  = 5'b00000;
  localparam logic [OPC_W-1:0] OP_STO  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_LD   = 5'b00010;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SELA_MEM = 2'd0;
  localparam logic [1:0] SELA_IMM = 2'd1;
  localparam logic [1:0] SELA_ALU = 2'd2;

  localparam logic SELB_MEM = 1'b0;
  localparam logic SELB_IMM = 1'b1;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
    logic       wr_acc;
    logic       rd_ram;
    logic       wr_ram;
    logic       is_hlt;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/bip_decoder.sv
`default_nettype none
// ============================================================================
// bip_decoder : combinational opcode -> datapath strobe map
// Revision    : 1.0
// ============================================================================
module bip_decoder
  import bip_defs::*;
(
  input  logic [OPC_W-1:0] opcode,
  output ctrl_t            ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_HLT:  ctrl.is_hlt = 1'b1;
      OP_STO:  ctrl.wr_ram = 1'b1;
      OP_LD: begin
        ctrl.rd_ram = 1'b1;
        ctrl.sel_a  = SELA_MEM;
        ctrl.wr_acc = 1'b1;
      end
      OP_LDI: begin
        ctrl.sel_a  = SELA_IMM;
        ctrl.wr_acc = 1'b1;
      end
      OP_ADD: begin
        ctrl.rd_ram = 1'b1;
        ctrl.sel_b  = SELB_MEM;
        ctrl.op     = ALU_ADD;
        ctrl.sel_a  = SELA_ALU;
        ctrl.wr_acc = 1'b1;
      end
      OP_ADDI: begin
        ctrl.sel_b  = SELB_IMM;
        ctrl.op     = ALU_ADD;
        ctrl.sel_a  = SELA_ALU;
        ctrl.wr_acc = 1'b1;
      end
      OP_SUB: begin
        ctrl.rd_ram = 1'b1;
        ctrl.sel_b  = SELB_MEM;
        ctrl.op     = ALU_SUB;
        ctrl.sel_a  = SELA_ALU;
        ctrl.wr_acc = 1'b1;
      end
      OP_SUBI: begin
        ctrl.sel_b  = SELB_IMM;
        ctrl.op     = ALU_SUB;
        ctrl.sel_a  = SELA_ALU;
        ctrl.wr_acc = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/bip_control_unit.sv
`default_nettype none
// ============================================================================
// bip_control_unit : BIP I sequencer - PC, FETCH/EXEC/HALT FSM, strobe gating
// Revision         : 1.0
// ============================================================================
module bip_control_unit
  import bip_defs::*;
#(
  parameter int                  PC_WIDTH     = 11,
  parameter int                  OPCODE_WIDTH = 5,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Enable,
  input  logic [15:0]         Instruction,
  output logic [PC_WIDTH-1:0] PcAddr,
  output logic [PC_WIDTH-1:0] Operand,
  output logic [1:0]          SelA,
  output logic                SelB,
  output logic                Op,
  output logic                WrAcc,
  output logic                RdRam,
  output logic                WrRam,
  output logic                Halted
);

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] pc, pc_next;
  logic [OPCODE_WIDTH-1:0] opcode;
  ctrl_t               dec;
  logic                in_exec;

  assign opcode  = Instruction[15 -: OPCODE_WIDTH];
  assign in_exec = (state == ST_EXEC);

  bip_decoder u_decoder (
    .opcode (opcode),
    .ctrl   (dec)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_FETCH;
      pc    <= RESET_VECTOR;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // PC wraps naturally at 2^PC_WIDTH; HLT leaves it pointing at the HLT word
  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      ST_FETCH: if (Enable) state_next = ST_EXEC;
      ST_EXEC: begin
        if (dec.is_hlt) begin
          state_next = ST_HALT;
        end else begin
          state_next = ST_FETCH;
          pc_next    = pc + PC_WIDTH'(1);
        end
      end
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_FETCH;
    endcase
  end

  assign PcAddr  = pc;
  assign Operand = in_exec ? Instruction[PC_WIDTH-1:0] : '0;
  assign SelA    = in_exec ? dec.sel_a  : SELA_MEM;
  assign SelB    = in_exec ? dec.sel_b  : SELB_MEM;
  assign Op      = in_exec ? dec.op     : ALU_ADD;
  assign WrAcc   = in_exec & dec.wr_acc;
  assign RdRam   = in_exec & dec.rd_ram;
  assign WrRam   = in_exec & dec.wr_ram;
  assign Halted  = (state == ST_HALT);

endmodule
`default_nettype wire
